uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler sharing one `uart_tx` transmitter between `NUM_REQ` byte-stream requesters. A requester wins arbitration and holds the transmitter for a whole message, which ends at the byte flagged `req_last`. The scheduler presents each byte to `uart_tx` through its `data_ready` / `trans_active` / `done_sig` handshake. It sits between the application message sources and the single `uart_tx` instance, replacing hard-wired per-message sequencing.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, 4096: idle-in-message watchdog limit, in `clk` cycles. Used only with `UART_SCHED_TIMEOUT_EN`.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_byte`  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- `req_last`  in  NUM_REQ  marks the final byte of a message; sampled with the byte.
- `req_ready`  out  NUM_REQ  byte accepted when `req_valid[i] & req_ready[i]`.
- `grant`  out  NUM_REQ  one-hot; identifies the requester that owns the transmitter.
- `tx_data_ready`  out  1  to `uart_tx.data_ready`.
- `tx_byte`  out  8  to `uart_tx.byte_trans`.
- `tx_trans_active`  in  1  from `uart_tx.trans_active`.
- `tx_done_sig`  in  1  from `uart_tx.done_sig`; one-cycle pulse at the end of the stop bit.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog aborts a message.

## Operation
- States: IDLE, FETCH, SEND, WAIT_DONE.
- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `ptr` (wrapping past NUM_REQ-1 to 0).
  - Register `grant` to that bit and go to FETCH.
  - With no requests, stay in IDLE.
- **FETCH**
  - `req_ready = grant` (combinational) while `tx_trans_active` = 0.
  - On the handshake: latch the byte into `tx_byte`, latch `req_last` into `last_q`, set `tx_data_ready` = 1, go to SEND.
  - If `req_valid[grant]` is low, the grant is held and the state does not change.
- **SEND**
  - Hold `tx_data_ready` = 1 and `tx_byte` stable until `tx_trans_active` = 1 is sampled.
  - Then clear `tx_data_ready` and go to WAIT_DONE.
- **WAIT_DONE**
  - Wait for `tx_done_sig`.
  - If `last_q` = 1: clear `grant`, set `ptr` = granted index + 1 (mod NUM_REQ), go to IDLE.
  - If `last_q` = 0: go to FETCH.
- `tx_done_sig` is ignored in every state except WAIT_DONE.
- Changes on `req_valid` of non-granted requesters never preempt the message in progress.
- `req_ready` is 0 for all non-granted requesters at all times.
- `ptr` is 0 out of reset, so requester 0 has highest priority first.

## Timing
- **Reset values** (asynchronous assert, synchronous release):
  - state = IDLE; `ptr` = 0; `last_q` = 0; watchdog counter = 0.
  - `grant` = 0, `req_ready` = 0, `tx_data_ready` = 0, `tx_byte` = 8'h00, `busy` = 0, `timeout_err` = 0.
- **Reset mid-message** drops `tx_data_ready` immediately. A byte already inside `uart_tx` finishes on its own. The interrupted message is not resumed.
- **Latency** (assuming the granted requester holds `req_valid` and the transmitter is idle):
  - `req_valid` seen in IDLE at cycle 0.
  - `grant` asserted at cycle 1, with `req_ready` in the same cycle.
  - `tx_data_ready` high at cycle 2.
- **Inter-byte gap**: `tx_done_sig` in cycle n gives FETCH at n+1 and `tx_data_ready` at n+2.
- **Back-to-back messages**: WAIT_DONE with `last_q` = 1 gives IDLE at n+1 and the new `grant` at n+2. There is no idle bit-time beyond this.
- **Simultaneous requests**: resolved only from `ptr`. A request arriving in the same cycle as the release loses to nothing; it is considered in IDLE on the next cycle.

## Configuration
- Macro: `UART_SCHED_TIMEOUT_EN`.
- **Defined**:
  - A counter runs in FETCH while `req_valid[grant]` = 0 and clears on the handshake or on leaving FETCH.
  - When it reaches TIMEOUT_CYCLES-1, the scheduler pulses `timeout_err` for 1 cycle, clears `grant`, advances `ptr` past the offender, and goes to IDLE.
- **Undefined**:
  - The counter is not built and `timeout_err` is tied 0.
  - A stalled requester holds the transmitter indefinitely.

## Test plan
- **Single message**: after reset, requester 2 sends 8'h48 then 8'h49 (`req_last` on 8'h49), with a `uart_tx` model at CLKS_PER_BIT=4.
  - `grant` = 4'b0100 at cycle 1.
  - The line carries 'H' then 'I'.
  - `grant` returns to 0 one cycle after the second `tx_done_sig`.
- **Round-robin fairness**: requesters 0 and 1 both request continuously with 1-byte messages.
  - Grants alternate 0,1,0,1.
  - After requester 1 is served, `ptr` = 2 and the next winner is 0.
- **No preemption**: requester 3 sends a 3-byte message; requester 0 asserts `req_valid` after byte 1.
  - Bytes 2 and 3 still come from requester 3.
  - Requester 0 is granted 2 cycles after the final `tx_done_sig`.
- **Handshake**: `tx_trans_active` held low for 10 cycles after `tx_data_ready` rises.
  - `tx_data_ready` and `tx_byte` stay stable.
  - A spurious `tx_done_sig` pulse in SEND is ignored.
- **Reset mid-message**: assert `rst_n` = 0 during WAIT_DONE of byte 2.
  - All outputs go to reset values in the same cycle.
  - After release, requester 0 wins over requester 1.
- **Watchdog** (`UART_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=16): requester 1 deasserts `req_valid` mid-message.
  - `timeout_err` pulses 16 cycles into the FETCH stall and `grant` clears.
  - Requester 2, which is pending, is granted next.

Source files
------------

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one uart_tx among NUM_REQ byte-stream requesters
// Optional idle-in-message watchdog: define UART_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_data_ready,
    output logic [7:0]           tx_byte,
    input  logic                 tx_trans_active,
    input  logic                 tx_done_sig,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               last_q, last_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_data_ready_q, tx_data_ready_d;
    logic               timeout_err_q, timeout_err_d;

    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic [PW:0]        cand;
    logic [PW-1:0]      gidx_inc;
    logic               grant_valid;
    logic               handshake;
    logic               wd_abort;

    // First requesting index at or above ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    assign gidx_inc    = (gidx_q == PW'(NUM_REQ-1)) ? '0 : gidx_q + 1'b1;
    assign grant_valid = |(req_valid & grant_q);
    assign handshake   = (state_q == FETCH) && grant_valid && !tx_trans_active;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_abort = (state_q == FETCH) && !grant_valid && (wd_cnt_q == CW'(TIMEOUT_CYCLES-1));

    // Counts stalled FETCH cycles; any exit from FETCH or an accepted byte restarts it.
    always_comb begin
        wd_cnt_d = '0;
        if ((state_q == FETCH) && !handshake && !wd_abort) begin
            wd_cnt_d = grant_valid ? wd_cnt_q : wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_abort = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        gidx_d          = gidx_q;
        grant_d         = grant_q;
        last_d          = last_q;
        tx_byte_d       = tx_byte_q;
        tx_data_ready_d = tx_data_ready_q;
        timeout_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = NUM_REQ'(1) << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (handshake) begin
                    tx_byte_d       = req_byte[{gidx_q, 3'b000} +: 8];
                    last_d          = |(req_last & grant_q);
                    tx_data_ready_d = 1'b1;
                    state_d         = SEND;
                end else if (wd_abort) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    ptr_d         = gidx_inc;
                    state_d       = IDLE;
                end
            end
            SEND: begin
                if (tx_trans_active) begin
                    tx_data_ready_d = 1'b0;
                    state_d         = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done_sig) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = gidx_inc;
                        state_d = IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            gidx_q          <= '0;
            grant_q         <= '0;
            last_q          <= 1'b0;
            tx_byte_q       <= 8'h00;
            tx_data_ready_q <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            gidx_q          <= gidx_d;
            grant_q         <= grant_d;
            last_q          <= last_d;
            tx_byte_q       <= tx_byte_d;
            tx_data_ready_q <= tx_data_ready_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign req_ready     = ((state_q == FETCH) && !tx_trans_active) ? grant_q : '0;
    assign grant         = grant_q;
    assign tx_data_ready = tx_data_ready_q;
    assign tx_byte       = tx_byte_q;
    assign busy          = (state_q != IDLE);
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized bench for uart_tx_sched against a message-order reference model
module tb_uart_tx_sched;
    localparam int NUM        = 4;
    localparam int TMO        = 16;
    localparam int BIT_CYCLES = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NUM-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*NUM-1:0] req_byte;
    logic             tx_data_ready, tx_trans_active, tx_done_sig, busy, timeout_err;
    logic [7:0]       tx_byte;

    uart_tx_sched #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_byte        (req_byte),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .grant           (grant),
        .tx_data_ready   (tx_data_ready),
        .tx_byte         (tx_byte),
        .tx_trans_active (tx_trans_active),
        .tx_done_sig     (tx_done_sig),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    logic [8:0] src_q [NUM][$];
    bit         hold [NUM];
    bit         at_start [NUM];
    bit         pop_pend [NUM];
    bit         stall_en, spur_en, hs_rand;
    int         fixed_delay;
    bit         ua_busy, ua_accept, ua_spur;
    int         ua_cnt, ua_wait, ua_delay;
    logic [7:0] ua_byte0;
    int         rec[$];
    int         exp_q[$];
    int         mptr;
    int         n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int oh_idx(input logic [NUM-1:0] v);
        int idx = 15;
        int cnt = 0;
        for (int i = 0; i < NUM; i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : 15;
    endfunction

    // Requester sources and a uart_tx stand-in (4 clocks/bit, 10 bits) on the falling edge.
    initial begin
        logic [8:0] ent;
        tx_trans_active = 1'b0;
        tx_done_sig     = 1'b0;
        req_valid       = '0;
        req_byte        = '0;
        req_last        = '0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < NUM; r++) begin
                if (pop_pend[r] && src_q[r].size() > 0) begin
                    ent         = src_q[r].pop_front();
                    at_start[r] = ent[8];
                end
                pop_pend[r] = 1'b0;
            end
            tx_done_sig = 1'b0;
            if (ua_accept) begin
                ua_busy   = 1'b1;
                ua_cnt    = 0;
                ua_accept = 1'b0;
            end
            if (ua_busy) begin
                ua_cnt++;
                if (ua_cnt >= BIT_CYCLES) begin
                    ua_busy         = 1'b0;
                    tx_trans_active = 1'b0;
                    tx_done_sig     = 1'b1;
                end else begin
                    tx_trans_active = 1'b1;
                end
            end else if (ua_spur) begin
                tx_done_sig = 1'b1;
                ua_spur     = 1'b0;
            end
            for (int r = 0; r < NUM; r++) begin
                ent = (src_q[r].size() > 0) ? src_q[r][0] : 9'h000;
                req_valid[r] = (src_q[r].size() > 0) && !hold[r] &&
                               !(stall_en && !at_start[r] && ($urandom_range(0, 3) == 0));
                req_byte[8*r +: 8] = ent[7:0];
                req_last[r]        = ent[8];
            end
            #1;
            for (int r = 0; r < NUM; r++) pop_pend[r] = req_valid[r] && req_ready[r];
            if (!ua_busy && !ua_accept && tx_data_ready) begin
                if (ua_wait == 0) begin
                    ua_delay = hs_rand ? int'($urandom_range(0, 10)) : fixed_delay;
                    ua_byte0 = tx_byte;
                end else begin
                    check("hs_byte_hold", tx_byte, ua_byte0);
                end
                if (ua_wait >= ua_delay) begin
                    rec.push_back(oh_idx(grant) * 256 + int'(tx_byte));
                    ua_accept = 1'b1;
                    ua_wait   = 0;
                end else begin
                    if (spur_en && ua_wait == ua_delay / 2) ua_spur = 1'b1;
                    ua_wait++;
                end
            end else if (ua_wait != 0) begin
                check("hs_drdy_hold", tx_data_ready, 1'b1);
                ua_wait = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic push_byte(input int r, input logic [7:0] b, input bit last);
        src_q[r].push_back({last, b});
    endtask

    // Reference: whole messages, winner = first pending requester at or above ptr.
    task automatic build_expected();
        int         pos [NUM];
        bit         found;
        int         r;
        logic [8:0] e;
        for (int i = 0; i < NUM; i++) pos[i] = 0;
        forever begin
            found = 1'b0;
            r     = 0;
            for (int k = 0; k < NUM && !found; k++) begin
                r = (mptr + k) % NUM;
                if (pos[r] < src_q[r].size()) found = 1'b1;
            end
            if (!found) break;
            do begin
                e = src_q[r][pos[r]];
                exp_q.push_back(r * 256 + int'(e[7:0]));
                pos[r]++;
            end while (!e[8] && pos[r] < src_q[r].size());
            mptr = (r + 1) % NUM;
        end
    endtask

    function automatic bit all_empty();
        for (int r = 0; r < NUM; r++) if (src_q[r].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic finish_session(input string tag);
        bit ok = 1'b0;
        int n;
        for (int c = 0; c < 20000 && !ok; c++) begin
            tick();
            ok = all_empty() && !busy && !ua_busy && !ua_accept && (rec.size() >= exp_q.size());
        end
        check({tag, "_drained"}, ok, 1'b1);
        check({tag, "_count"}, rec.size(), exp_q.size());
        n = (rec.size() < exp_q.size()) ? rec.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_src_byte"}, rec[i], exp_q[i]);
        rec.delete();
        exp_q.delete();
    endtask

    task automatic wait_dones(input int n, input string tag);
        int cnt = 0;
        for (int c = 0; c < 3000 && cnt < n; c++) begin
            tick();
            if (tx_done_sig) cnt++;
        end
        check({tag, "_dones"}, cnt, n);
    endtask

    task automatic wait_rec(input int n, input string tag);
        for (int c = 0; c < 3000 && rec.size() < n; c++) tick();
        check({tag, "_rec"}, rec.size() >= n, 1'b1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; mptr = 0;
        stall_en = 0; spur_en = 0; hs_rand = 0; fixed_delay = 0;
        ua_busy = 0; ua_accept = 0; ua_spur = 0; ua_cnt = 0; ua_wait = 0; ua_delay = 0;
        for (int r = 0; r < NUM; r++) begin
            hold[r] = 0; at_start[r] = 1; pop_pend[r] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_grant", grant, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_data_ready", tx_data_ready, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Single message from requester 2: "HI"
        push_byte(2, 8'h48, 0);
        push_byte(2, 8'h49, 1);
        build_expected();
        tick();
        check("lat_c0_grant", grant, 0);
        tick();
        check("lat_c1_grant", grant, 4'b0100);
        check("lat_c1_req_ready", req_ready, 4'b0100);
        check("lat_c1_drdy", tx_data_ready, 0);
        tick();
        check("lat_c2_drdy", tx_data_ready, 1);
        check("lat_c2_byte", tx_byte, 8'h48);
        wait_dones(2, "single");
        check("single_grant_at_done", grant, 4'b0100);
        tick();
        check("single_grant_release", grant, 0);
        finish_session("single");

        // Round-robin between requesters 0 and 1, one-byte messages
        for (int i = 0; i < 3; i++) push_byte(0, 8'h10 + 8'(i), 1);
        for (int i = 0; i < 2; i++) push_byte(1, 8'h20 + 8'(i), 1);
        build_expected();
        finish_session("rr");

        // No preemption: requester 0 becomes valid during requester 3's message
        push_byte(3, 8'h31, 0);
        push_byte(3, 8'h32, 0);
        push_byte(3, 8'h33, 1);
        push_byte(0, 8'h0A, 1);
        hold[0] = 1;
        build_expected();
        wait_rec(1, "nopre");
        hold[0] = 0;
        wait_dones(3, "nopre");
        tick();
        check("nopre_release", grant, 0);
        tick();
        check("nopre_next_grant", grant, 4'b0001);
        finish_session("nopre");

        // Transmitter slow to accept, spurious done while waiting
        fixed_delay = 10;
        spur_en     = 1;
        push_byte(2, 8'hC3, 0);
        push_byte(2, 8'h3C, 1);
        build_expected();
        finish_session("hs");
        fixed_delay = 0;

        // Randomized traffic
        hs_rand  = 1;
        stall_en = 1;
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < NUM; r++) begin
                int nm = $urandom_range(0, 2);
                for (int m = 0; m < nm; m++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
                end
            end
            build_expected();
            finish_session("rand");
        end
        hs_rand = 0; stall_en = 0; spur_en = 0;

        // Reset during WAIT_DONE of byte 2
        push_byte(0, 8'hA1, 0);
        push_byte(0, 8'hA2, 0);
        push_byte(0, 8'hA3, 1);
        wait_rec(2, "rstmid");
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_grant", grant, 0);
        check("rstmid_req_ready", req_ready, 0);
        check("rstmid_drdy", tx_data_ready, 0);
        check("rstmid_tx_byte", tx_byte, 8'h00);
        check("rstmid_busy", busy, 0);
        check("rstmid_timeout_err", timeout_err, 0);
        check("rstmid_sent_count", rec.size(), 2);
        if (rec.size() >= 2) begin
            check("rstmid_byte1", rec[0], 8'hA1);
            check("rstmid_byte2", rec[1], 8'hA2);
        end
        rec.delete();
        src_q[0].delete();
        at_start[0] = 1;
        for (int c = 0; c < 200 && ua_busy; c++) tick();
        tick(); tick();
        rst_n = 1'b1;
        mptr = 0;
        tick();
        push_byte(1, 8'h31, 1);
        push_byte(0, 8'h30, 1);
        build_expected();
        finish_session("rstmid");

`ifdef UART_SCHED_TIMEOUT_EN
        // Watchdog: requester 1 stalls mid-message, requester 2 pending
        begin
            int cyc = 0;
            push_byte(1, 8'h51, 0);
            push_byte(1, 8'h52, 1);
            wait_rec(1, "wd");
            hold[1] = 1;
            push_byte(2, 8'h61, 1);
            wait_dones(1, "wd");
            for (int c = 0; c < 200 && !timeout_err; c++) begin
                tick();
                cyc++;
            end
            check("wd_pulse_cycle", cyc, TMO + 1);
            check("wd_grant_clear", grant, 0);
            tick();
            check("wd_pulse_width", timeout_err, 0);
            src_q[1].delete();
            hold[1] = 0;
            at_start[1] = 1;
            wait_rec(2, "wd");
            if (rec.size() >= 2) begin
                check("wd_first", rec[0], 256 + 8'h51);
                check("wd_next_winner", rec[1], 512 + 8'h61);
            end
            for (int c = 0; c < 200 && (busy || ua_busy); c++) tick();
            rec.delete();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
